multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and write-back. It drives the PC write enable and next-PC select, and produces all datapath enables from the opcode/funct of the held instruction. It sits between the instruction register and the PC, register file, ALU and memory, and stalls on a memory-ready handshake.

## Interface
- `INIT_STATE`, default 3'd0 (`S_FETCH`): state entered on reset.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces `S_FETCH`.
- `op` in 6: IR[31:26], stable from `S_DECODE` until the next fetch.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, valid in `S_EXEC`.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC register load enable.
- `pc_src` out 2: next-PC select. 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr).
- `ir_write` out 1: instruction register load.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 2: 0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg` out 2: 0 = ALU, 1 = MDR, 2 = PC.
- `alu_src_b` out 2: 0 = reg, 1 = 4, 2 = ext imm.
- `alu_op` out 3: ADD, SUB, OR, LUI.
- `ext_op` out 1: 1 = sign extend, 0 = zero extend.
- `state` out 3: current state, for debug.

## Operation
- States: `S_FETCH`(0), `S_DECODE`(1), `S_EXEC`(2), `S_MEM`(3), `S_WB`(4). Codes 5–7 are illegal and go to `S_FETCH` on the next edge.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr. Any other op/funct is a NOP: `S_DECODE` → `S_FETCH`.
- `S_FETCH`:
  - `mem_read`=1.
  - While `mem_ready`=0: hold state, `ir_write`=`pc_write`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to `S_DECODE`.
- `S_DECODE`:
  - j: `pc_write`=1, `pc_src`=2.
  - jal: as j, plus `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2. PC still holds PC+4 this cycle.
  - jr: `pc_write`=1, `pc_src`=3.
  - Jumps and NOP go to `S_FETCH`; all others go to `S_EXEC`.
- `S_EXEC`:
  - beq: `alu_op`=SUB; `pc_write`=`zero`, `pc_src`=1; then `S_FETCH`.
  - lw/sw: `alu_src_b`=2, `ext_op`=1, ADD; then `S_MEM`.
  - R-type and ori/lui: then `S_WB`.
- `S_MEM`:
  - lw: `mem_read`=1; sw: `mem_write`=1; the strobe stays asserted while waiting.
  - While `mem_ready`=0: hold.
  - On ready: sw → `S_FETCH`, lw → `S_WB`.
- `S_WB`:
  - `reg_write`=1 for exactly one cycle, then `S_FETCH`.
  - R-type: `reg_dst`=1. ori/lui: `reg_dst`=0. lw: `mem_to_reg`=1.
- Outputs are combinational from `state`, `op`, `funct`, `zero`, `mem_ready`. Every enable not listed above is 0.

## Timing
- Reset is asynchronous: `state`=0 immediately. While `reset`=1, every enable is 0 (`pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write`) and every select is 0.
- Reset asserted mid-instruction aborts it. No partial write occurs after the reset edge, and fetch restarts from the PC the PC register reloads.
- Latencies with zero wait states:
  - j/jal/jr/NOP: 2 cycles.
  - beq: 3 cycles.
  - R-type/ori/lui/sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle on `mem_ready` adds 1 cycle.
- `pc_write` pulses once per instruction in `S_FETCH`. It pulses a second time for jumps and for taken branches, and never more.
- `mem_ready` is sampled only in `S_FETCH` and `S_MEM` and is ignored elsewhere.

## Structure
- Shared package `ctrl_pkg`: state codes, opcode/funct constants (R=6'h00, ORI=0d, LUI=0f, LW=23, SW=2b, BEQ=04, J=02, JAL=03; ADDU=21, SUBU=23, JR=08), and the `pc_src`/`reg_dst`/`mem_to_reg`/`alu_op` encodings.
- One natural sub-module, `instr_decode`: combinational op/funct → instruction class (RTYPE, IMM, LOAD, STORE, BRANCH, JUMP, JAL, JR, NOP). The FSM uses only the class.

## Test plan
- Reset: assert `reset` mid-`S_EXEC`. Required: `state`=0 with no clock edge, all enables 0. After release with `mem_ready`=1, `ir_write`=1 on the first edge.
- addu ($3=$1+$2), `mem_ready` tied 1: state sequence 0,1,2,4,0; `reg_write`=1 only in state 4 with `reg_dst`=1; `pc_write` exactly once.
- lw with 2 wait cycles in each of fetch and mem: 9 cycles total; `mem_read` held through the waits; `reg_write` in `S_WB` with `mem_to_reg`=1.
- beq with `zero`=1, then beq with `zero`=0: `pc_write`=1 with `pc_src`=1 in `S_EXEC` for the first, 0 for the second; both take 3 cycles.
- jal at PC 0x3000: `S_DECODE` has `pc_write`=1, `pc_src`=2, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2; returns to `S_FETCH` after 2 cycles.
- Unsupported op 6'h3f: 2 cycles, no `reg_write`/`mem_write`; force `state`=7 and check it returns to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle MIPS control FSM.
//   - state codes (state_e)
//   - opcode / funct constants
//   - pc_src, reg_dst, mem_to_reg, alu_src_b and alu_op encodings
//   - instruction classes produced by instr_decode (iclass_e, decode_t)
//   - packed bundle of all datapath controls (ctrl_t)
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // Funct codes (IR[5:0]) for R-type
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Next-PC select
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_JR     = 2'd3;

    // Register file write destination
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    // Register file write data source
    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    // ALU B operand select
    localparam logic [1:0] ALU_B_REG  = 2'd0;
    localparam logic [1:0] ALU_B_FOUR = 2'd1;
    localparam logic [1:0] ALU_B_IMM  = 2'd2;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    typedef enum logic [3:0] {
        IC_NOP,
        IC_RTYPE,
        IC_IMM,
        IC_LOAD,
        IC_STORE,
        IC_BRANCH,
        IC_JUMP,
        IC_JAL,
        IC_JR
    } iclass_e;

    // Class plus the ALU operation that class needs in S_EXEC.
    typedef struct packed {
        iclass_e    iclass;
        logic [2:0] alu_op;
    } decode_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       ext_op;
    } ctrl_t;

    // Jumps and NOPs retire in S_DECODE; everything else needs S_EXEC.
    function automatic state_e decode_next(input iclass_e c);
        state_e nxt;
        case (c)
            IC_JUMP, IC_JAL, IC_JR, IC_NOP: nxt = S_FETCH;
            default:                        nxt = S_EXEC;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational op/funct -> instruction class.
//   op     in  6 : IR[31:26]
//   funct  in  6 : IR[5:0]
//   dec    out   : instruction class and its ALU operation
// Anything not in the supported set decodes to IC_NOP.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output decode_t    dec
);

    always_comb begin
        dec.iclass = IC_NOP;
        dec.alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin
                        dec.iclass = IC_RTYPE;
                        dec.alu_op = ALU_ADD;
                    end
                    FN_SUBU: begin
                        dec.iclass = IC_RTYPE;
                        dec.alu_op = ALU_SUB;
                    end
                    FN_JR:   dec.iclass = IC_JR;
                    default: dec.iclass = IC_NOP;
                endcase
            end
            OP_ORI: begin
                dec.iclass = IC_IMM;
                dec.alu_op = ALU_OR;
            end
            OP_LUI: begin
                dec.iclass = IC_IMM;
                dec.alu_op = ALU_LUI;
            end
            OP_LW:  dec.iclass = IC_LOAD;
            OP_SW:  dec.iclass = IC_STORE;
            OP_BEQ: begin
                dec.iclass = IC_BRANCH;
                dec.alu_op = ALU_SUB;
            end
            OP_J:    dec.iclass = IC_JUMP;
            OP_JAL:  dec.iclass = IC_JAL;
            default: dec.iclass = IC_NOP;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: main control FSM of the multi-cycle MIPS datapath.
// Sequences fetch / decode / execute / memory / write-back and stalls on
// mem_ready in S_FETCH and S_MEM.
//   clk, reset          : clock (rising edge), async active-high reset
//   op, funct           : held instruction fields
//   zero                : ALU zero flag (used in S_EXEC for beq)
//   mem_ready           : memory completes the current access this cycle
//   pc_write, pc_src    : PC load enable and next-PC select
//   ir_write            : instruction register load
//   mem_read, mem_write : memory strobes
//   reg_write, reg_dst, mem_to_reg : register file write controls
//   alu_src_b, alu_op, ext_op      : ALU controls
//   state               : current state (debug)
// All outputs are combinational from state and inputs, and forced to 0
// while reset is high.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [2:0] INIT_STATE = 3'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       ext_op,
    output logic [2:0] state
);

    // Plain vector so illegal codes 5..7 are representable and recoverable.
    logic [2:0] state_q, state_d;
    decode_t    dec;
    ctrl_t      ctrl;

    instr_decode u_decode (
        .op    (op),
        .funct (funct),
        .dec   (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = decode_next(dec.iclass);
            S_EXEC: begin
                case (dec.iclass)
                    IC_LOAD, IC_STORE: state_d = S_MEM;
                    IC_RTYPE, IC_IMM:  state_d = S_WB;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (!mem_ready) begin
                    state_d = S_MEM;
                end else if (dec.iclass == IC_LOAD) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_PLUS4;
                end
            end
            S_DECODE: begin
                case (dec.iclass)
                    IC_JUMP: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_JUMP;
                    end
                    IC_JAL: begin
                        // Link uses the PC value that still holds PC+4 this cycle.
                        ctrl.pc_write   = 1'b1;
                        ctrl.pc_src     = PC_SRC_JUMP;
                        ctrl.reg_write  = 1'b1;
                        ctrl.reg_dst    = REG_DST_RA;
                        ctrl.mem_to_reg = M2R_PC;
                    end
                    IC_JR: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_JR;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (dec.iclass)
                    IC_RTYPE: ctrl.alu_op = dec.alu_op;
                    IC_IMM: begin
                        ctrl.alu_src_b = ALU_B_IMM;
                        ctrl.alu_op    = dec.alu_op;
                    end
                    IC_LOAD, IC_STORE: begin
                        ctrl.alu_src_b = ALU_B_IMM;
                        ctrl.ext_op    = 1'b1;
                        ctrl.alu_op    = ALU_ADD;
                    end
                    IC_BRANCH: begin
                        ctrl.alu_op   = ALU_SUB;
                        ctrl.pc_write = zero;
                        ctrl.pc_src   = PC_SRC_BRANCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Strobe stays up for the whole wait.
                ctrl.mem_read  = (dec.iclass == IC_LOAD);
                ctrl.mem_write = (dec.iclass == IC_STORE);
            end
            S_WB: begin
                ctrl.reg_write = 1'b1;
                if (dec.iclass == IC_RTYPE) begin
                    ctrl.reg_dst = REG_DST_RD;
                end
                if (dec.iclass == IC_LOAD) begin
                    ctrl.mem_to_reg = M2R_MDR;
                end
            end
            default: ;
        endcase
    end

    // Gate on reset so nothing is written while it is held.
    assign {pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
            reg_dst, mem_to_reg, alu_src_b, alu_op, ext_op} = reset ? '0 : ctrl;

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

    localparam int K_ADDU = 0;
    localparam int K_SUBU = 1;
    localparam int K_ORI  = 2;
    localparam int K_LUI  = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_J    = 7;
    localparam int K_JAL  = 8;
    localparam int K_JR   = 9;
    localparam int K_NOP  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, ext_op;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [2:0] alu_op, state;
    logic [19:0] obs;

    int checks = 0;
    int errors = 0;

    logic [5:0] bad_ops [6] = '{6'h3f, 6'h01, 6'h05, 6'h08, 6'h2a, 6'h20};

    multi_cycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .ext_op     (ext_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign obs = {state, pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_b, alu_op, ext_op};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // What each phase of a given instruction must drive, straight from the rules.
    function automatic logic [19:0] exp_vec(input int ph, input int k, input bit z, input bit rdy);
        logic       pw = 1'b0;
        logic [1:0] ps = 2'd0;
        logic       irw = 1'b0, mr = 1'b0, mw = 1'b0, rw = 1'b0, ext = 1'b0;
        logic [1:0] rd = 2'd0, m2r = 2'd0, asb = 2'd0;
        logic [2:0] aop = 3'd0;
        logic [2:0] st = ph[2:0];
        case (ph)
            0: begin
                mr = 1'b1;
                if (rdy) begin irw = 1'b1; pw = 1'b1; end
            end
            1: begin
                if (k == K_J)   begin pw = 1'b1; ps = 2'd2; end
                if (k == K_JAL) begin pw = 1'b1; ps = 2'd2; rw = 1'b1; rd = 2'd2; m2r = 2'd2; end
                if (k == K_JR)  begin pw = 1'b1; ps = 2'd3; end
            end
            2: begin
                case (k)
                    K_SUBU: aop = 3'd1;
                    K_ORI:  begin asb = 2'd2; aop = 3'd2; end
                    K_LUI:  begin asb = 2'd2; aop = 3'd3; end
                    K_LW, K_SW: begin asb = 2'd2; ext = 1'b1; end
                    K_BEQ:  begin aop = 3'd1; pw = z; ps = 2'd1; end
                    default: ;
                endcase
            end
            3: begin
                mr = (k == K_LW);
                mw = (k == K_SW);
            end
            4: begin
                rw = 1'b1;
                if (k == K_ADDU || k == K_SUBU) rd = 2'd1;
                if (k == K_LW) m2r = 2'd1;
            end
            default: ;
        endcase
        return {st, pw, ps, irw, mr, mw, rw, rd, m2r, asb, aop, ext};
    endfunction

    task automatic encode(input int k, output logic [5:0] o, output logic [5:0] f);
        f = 6'($urandom);
        case (k)
            K_ADDU: begin o = 6'h00; f = 6'h21; end
            K_SUBU: begin o = 6'h00; f = 6'h23; end
            K_JR:   begin o = 6'h00; f = 6'h08; end
            K_ORI:  o = 6'h0d;
            K_LUI:  o = 6'h0f;
            K_LW:   o = 6'h23;
            K_SW:   o = 6'h2b;
            K_BEQ:  o = 6'h04;
            K_J:    o = 6'h02;
            K_JAL:  o = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    o = bad_ops[$urandom_range(0, 5)];
                end else begin
                    o = 6'h00;
                    while (f == 6'h21 || f == 6'h23 || f == 6'h08) f = 6'($urandom);
                end
            end
        endcase
    endtask

    // Entered just after a falling edge with the DUT in S_FETCH.
    task automatic run_instr(input int k, input int wf, input int wm, input bit z,
                             input string tag);
        int ph_q[$];
        bit rdy_q[$];
        logic [5:0] o, f;
        int pcw = 0;
        int exp_pcw;
        bit is_jump = (k == K_J || k == K_JAL || k == K_JR);
        encode(k, o, f);
        for (int i = 0; i < wf; i++) begin ph_q.push_back(0); rdy_q.push_back(1'b0); end
        ph_q.push_back(0); rdy_q.push_back(1'b1);
        ph_q.push_back(1); rdy_q.push_back(1'($urandom));
        if (!is_jump && k != K_NOP) begin
            ph_q.push_back(2); rdy_q.push_back(1'($urandom));
            if (k == K_LW || k == K_SW) begin
                for (int i = 0; i < wm; i++) begin ph_q.push_back(3); rdy_q.push_back(1'b0); end
                ph_q.push_back(3); rdy_q.push_back(1'b1);
            end
            if (k == K_LW || k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI) begin
                ph_q.push_back(4); rdy_q.push_back(1'($urandom));
            end
        end
        for (int i = 0; i < ph_q.size(); i++) begin
            mem_ready = rdy_q[i];
            zero = (ph_q[i] == 2) ? z : 1'($urandom);
            if (ph_q[i] == 0) begin
                op = 6'($urandom);
                funct = 6'($urandom);
            end else begin
                op = o;
                funct = f;
            end
            #1;
            check_eq($sformatf("%s c%0d", tag, i), 32'(obs),
                     32'(exp_vec(ph_q[i], k, z, rdy_q[i])));
            if (pc_write) pcw++;
            @(posedge clk);
            @(negedge clk);
        end
        exp_pcw = 1 + ((is_jump || (k == K_BEQ && z)) ? 1 : 0);
        check_eq({tag, " pcw"}, pcw, exp_pcw);
        #1;
        check_eq({tag, " end"}, 32'(state), 32'd0);
    endtask

    initial begin
        mem_ready = 1'b1;
        #2;
        check_eq("por", 32'(obs), 32'd0);
        @(negedge clk);
        #1 check_eq("por hold", 32'(obs), 32'd0);
        reset = 1'b0;

        // Directed cases
        run_instr(K_ADDU, 0, 0, 1'b0, "addu");
        run_instr(K_LW,   2, 2, 1'b0, "lw_wait");
        run_instr(K_BEQ,  0, 0, 1'b1, "beq_t");
        run_instr(K_BEQ,  0, 0, 1'b0, "beq_nt");
        run_instr(K_JAL,  0, 0, 1'b0, "jal");
        run_instr(K_NOP,  0, 0, 1'b0, "nop");
        run_instr(K_SW,   1, 2, 1'b0, "sw_wait");

        // Reset in the middle of an addu in S_EXEC
        op = 6'h00; funct = 6'h21; mem_ready = 1'b1; zero = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        #1 check_eq("rst pre", 32'(state), 32'd2);
        reset = 1'b1;
        #1 check_eq("rst async", 32'(obs), 32'd0);
        @(posedge clk); @(negedge clk);
        #1 check_eq("rst hold", 32'(obs), 32'd0);
        reset = 1'b0; mem_ready = 1'b1;
        #1 check_eq("rst fetch", 32'(obs), 32'(exp_vec(0, K_ADDU, 1'b0, 1'b1)));
        @(posedge clk); @(negedge clk);
        #1 check_eq("rst decode", 32'(state), 32'd1);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_eq("rst pulse", 32'(state), 32'd0);

        // Illegal state recovers to S_FETCH even with mem_ready high
        force dut.state_q = 3'd7;
        mem_ready = 1'b1;
        #1 check_eq("ill out", 32'(obs), 32'({3'd7, 17'd0}));
        release dut.state_q;
        @(posedge clk); @(negedge clk);
        #1 check_eq("ill rec", 32'(state), 32'd0);

        for (int n = 0; n < 300; n++) begin
            run_instr($urandom_range(0, 10), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom), $sformatf("r%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
